// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO.
// Used by sync_fifo and sync_fifo_mem.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  // Two-bit encoding is {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: one write port and one registered read port
// with read enable. The read register clears on reset; the array itself does not.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-edge write to raddr_i returns the old word, which is what a
  // read-and-write on a full FIFO needs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a one-cycle registered read.
// Optional status outputs (count, overflow, underflow) under SYNC_FIFO_STATUS_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_STATUS_EN
  ,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_acc, rd_acc;
  fifo_op_e      op;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A write into a full FIFO is still taken when a read frees the slot on the same edge.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    case (op)
      OP_WR: begin
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end
      OP_RD: begin
        rptr_d  = rptr_q + 1'b1;
        count_d = count_q - 1'b1;
      end
      OP_BOTH: begin
        wptr_d = wptr_q + 1'b1;
        rptr_d = rptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (data_out)
  );

`ifdef SYNC_FIFO_STATUS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow_d  = wr_en && !wr_acc;
  assign underflow_d = rd_en && empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, corner-case sequences
// and random traffic compared against a queue-based model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rstn;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_STATUS_EN
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef SYNC_FIFO_STATUS_EN
    ,
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Reference behaviour from the rules: read takes the head if anything is
  // stored; write is kept if there is room or a read happens on the same edge.
  task automatic model_apply(input logic wr, input logic rd, input logic [DW-1:0] din);
    int  sz;
    bit  rd_ok;
    bit  wr_ok;
    sz    = mq.size();
    rd_ok = rd && (sz > 0);
    wr_ok = wr && ((sz < DEPTH) || rd);
    m_ovf = wr && !wr_ok;
    m_udf = rd && (sz == 0);
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) mq.push_back(din);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},  data_out, m_dout);
    chk({tag, ".full"},  full,  mq.size() == DEPTH);
    chk({tag, ".empty"}, empty, mq.size() == 0);
`ifdef SYNC_FIFO_STATUS_EN
    chk({tag, ".count"}, count, mq.size());
    chk({tag, ".ovf"},   overflow,  m_ovf);
    chk({tag, ".udf"},   underflow, m_udf);
`endif
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [DW-1:0] din);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    #1;
    model_apply(wr, rd, din);
  endtask

  task automatic step(input string tag, input logic wr, input logic rd, input logic [DW-1:0] din);
    drive(wr, rd, din);
    check_model(tag);
  endtask

  initial begin
    rstn    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    model_reset();

    // Fill 22..29, one rejected write of 30, then ten reads.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, DW'(22 + i), 8'd0, (i == 7), 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'd30, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 10; j++)
      vecs[9 + j] = '{1'b0, 1'b1, 8'd0, (j < 8) ? DW'(22 + j) : 8'd29, 1'b0, (j >= 7), 1'b0, (j >= 8)};

    #20;
    chk("reset.empty", empty, 1);
    chk("reset.full",  full, 0);
    chk("reset.dout",  data_out, 0);
`ifdef SYNC_FIFO_STATUS_EN
    chk("reset.count", count, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].wr, vecs[v].rd, vecs[v].din);
      chk($sformatf("vec%0d.dout", v),  data_out, vecs[v].dout);
      chk($sformatf("vec%0d.full", v),  full,     vecs[v].full);
      chk($sformatf("vec%0d.empty", v), empty,    vecs[v].empty);
`ifdef SYNC_FIFO_STATUS_EN
      chk($sformatf("vec%0d.ovf", v),   overflow,  vecs[v].ovf);
      chk($sformatf("vec%0d.udf", v),   underflow, vecs[v].udf);
`endif
    end

    // Asynchronous reset in the middle of traffic, away from any clock edge.
    for (int i = 0; i < 5; i++) step("pre_rst.wr", 1'b1, 1'b0, DW'(40 + i));
    step("pre_rst.rd", 1'b0, 1'b1, 8'd0);
    chk("pre_rst.dout40", data_out, 40);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst.empty", empty, 1);
    chk("async_rst.full",  full, 0);
    chk("async_rst.dout",  data_out, 0);
`ifdef SYNC_FIFO_STATUS_EN
    chk("async_rst.count", count, 0);
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Streaming from empty: first edge only writes, then one word in flight.
    for (int k = 0; k < 100; k++) begin
      step("stream", 1'b1, 1'b1, DW'(22 + k));
      chk("stream.dout_abs", data_out, (k == 0) ? 0 : 22 + k - 1);
      chk("stream.full_abs", full, 0);
    end
    for (int k = 0; k < 70; k++) begin
      step("stream_drain", 1'b0, 1'b1, 8'd0);
      chk("stream_drain.dout_abs", data_out, 121);
      chk("stream_drain.empty_abs", empty, 1);
    end

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) step("fill0_7", 1'b1, 1'b0, DW'(i));
    chk("fill0_7.full_abs", full, 1);
    step("full_both", 1'b1, 1'b1, 8'd8);
    chk("full_both.dout_abs", data_out, 0);
    chk("full_both.full_abs", full, 1);
    for (int i = 0; i < 8; i++) begin
      step("drain1_8", 1'b0, 1'b1, 8'd0);
      chk("drain1_8.dout_abs", data_out, i + 1);
    end
    chk("drain1_8.empty_abs", empty, 1);

    // Wrap-around: three fill/drain rounds with distinct data.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step("wrap.fill", 1'b1, 1'b0, DW'(100 + 16 * r + i));
      chk("wrap.full_abs", full, 1);
      for (int i = 0; i < 8; i++) begin
        step("wrap.drain", 1'b0, 1'b1, 8'd0);
        chk("wrap.dout_abs", data_out, 100 + 16 * r + i);
      end
      chk("wrap.empty_abs", empty, 1);
    end

    // Random traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 8; ph++) begin
      int wbias;
      int rbias;
      wbias = (ph % 2 == 0) ? 80 : 25;
      rbias = (ph % 2 == 0) ? 25 : 80;
      for (int c = 0; c < 300; c++) begin
        logic w;
        logic r;
        w = ($urandom_range(0, 99) < wbias);
        r = ($urandom_range(0, 99) < rbias);
        step("rand", w, r, DW'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
